// File: rtl/dc_pkg.sv
// rtl/dc_pkg.sv - shared types, limits and timing helper for the DC ramp controller
package dc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP_UP,
    ST_RAMP_DOWN,
    ST_DWELL,
    ST_STOP
  } dc_state_t;

  localparam logic [7:0] DUTY_MAX = 8'd100;

  function automatic logic [23:0] ms_to_cyc(input int unsigned ms, input int unsigned clk_fre);
    return 24'(ms * 1000 * clk_fre);
  endfunction

endpackage

// File: rtl/dc_ramp_ctrl_tick_gen.sv
// rtl/dc_ramp_ctrl_tick_gen.sv - loadable 24-bit down-counter pacing duty steps and dwell
module dc_tick_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] load_val,
  input  logic        en,
  output logic        expire
);

  logic [23:0] cnt_q, cnt_d;

  // expire must not depend on load: the parent decides whether to load from it
  assign expire = en && (cnt_q == 24'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = (cnt_q == 24'd0) ? load_val : cnt_q - 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dc_ramp_ctrl.sv
// rtl/dc_ramp_ctrl.sv - slews PWM duty toward a commanded target with safe direction reversal
module dc_ramp_ctrl
  import dc_pkg::*;
#(
  parameter int unsigned CLK_FRE = 50,
  parameter int unsigned STEP_MS = 10,
  parameter int unsigned DEAD_MS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_duty,
  input  logic       estop,
  output logic       dc_dir,
  output logic [7:0] dc_duty,
  output logic       at_target
);

  localparam logic [23:0] STEP_CYC = ms_to_cyc(STEP_MS, CLK_FRE);
  localparam logic [23:0] DEAD_CYC = ms_to_cyc(DEAD_MS, CLK_FRE);

  dc_state_t   state_q, state_d;
  logic        dir_q, dir_d;
  logic [7:0]  duty_q, duty_d;
  logic        tgt_dir_q, tgt_dir_d;
  logic [7:0]  tgt_duty_q, tgt_duty_d;
  logic        pend_q, pend_d;

  logic        accept;
  logic [7:0]  cmd_duty_clamped;
  logic [7:0]  eff_tgt;
  logic        tick_load;
  logic [23:0] tick_load_val;
  logic        tick_en;
  logic        tick_expire;

  assign cmd_ready = !estop && (state_q == ST_IDLE || state_q == ST_RAMP_UP ||
                                state_q == ST_RAMP_DOWN);
  assign accept           = cmd_valid && cmd_ready;
  assign cmd_duty_clamped = (cmd_duty > DUTY_MAX) ? DUTY_MAX : cmd_duty;
  assign eff_tgt          = pend_q ? 8'd0 : tgt_duty_q;
  assign tick_en          = (state_q == ST_RAMP_UP || state_q == ST_RAMP_DOWN ||
                             state_q == ST_DWELL);

  assign dc_dir    = dir_q;
  assign dc_duty   = duty_q;
  assign at_target = (state_q == ST_IDLE) && (duty_q == tgt_duty_q) && (dir_q == tgt_dir_q);

  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    duty_d        = duty_q;
    tgt_dir_d     = tgt_dir_q;
    tgt_duty_d    = tgt_duty_q;
    pend_d        = pend_q;
    tick_load     = 1'b0;
    tick_load_val = STEP_CYC - 24'd1;

    if (estop) begin
      state_d    = ST_STOP;
      duty_d     = 8'd0;
      tgt_duty_d = 8'd0;
      pend_d     = 1'b0;
    end else if (accept) begin
      tgt_dir_d  = cmd_dir;
      tgt_duty_d = cmd_duty_clamped;
      if (cmd_dir == dir_q || duty_q == 8'd0) begin
        pend_d = 1'b0;
        dir_d  = cmd_dir;
        if (cmd_duty_clamped > duty_q)      state_d = ST_RAMP_UP;
        else if (cmd_duty_clamped < duty_q) state_d = ST_RAMP_DOWN;
        else                                state_d = ST_IDLE;
      end else begin
        pend_d  = 1'b1;
        state_d = ST_RAMP_DOWN;
      end
      // Mid-ramp retargets keep the running step phase
      tick_load = (state_q == ST_IDLE) && (state_d != ST_IDLE);
    end else begin
      case (state_q)
        ST_STOP: state_d = ST_IDLE;
        ST_RAMP_UP: begin
          if (tick_expire) begin
            duty_d = duty_q + 8'd1;
            if (duty_d == eff_tgt) state_d = ST_IDLE;
          end
        end
        ST_RAMP_DOWN: begin
          if (tick_expire) begin
            duty_d = duty_q - 8'd1;
            if (duty_d == eff_tgt) begin
              if (pend_q) begin
                state_d       = ST_DWELL;
                tick_load     = 1'b1;
                tick_load_val = DEAD_CYC - 24'd1;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        ST_DWELL: begin
          if (tick_expire) begin
            dir_d  = tgt_dir_q;
            pend_d = 1'b0;
            if (tgt_duty_q != 8'd0) begin
              state_d   = ST_RAMP_UP;
              tick_load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= 1'b0;
      duty_q     <= 8'd0;
      tgt_dir_q  <= 1'b0;
      tgt_duty_q <= 8'd0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      duty_q     <= duty_d;
      tgt_dir_q  <= tgt_dir_d;
      tgt_duty_q <= tgt_duty_d;
      pend_q     <= pend_d;
    end
  end

  dc_tick_gen u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (tick_load),
    .load_val (tick_load_val),
    .en       (tick_en),
    .expire   (tick_expire)
  );

endmodule

// File: doc/dc_ramp_ctrl.md
# dc_ramp_ctrl

Speed-profile stage that sits directly upstream of the DC motor PWM driver and drives its `dc_dir` / `dc_duty` inputs. It accepts target direction/duty commands over a valid/ready handshake. It slews duty toward the target one percent per step and forces decelerate-to-zero, dwell, then reverse on any direction change. An emergency-stop input overrides everything and cuts duty to zero immediately.

## Interface
- `CLK_FRE`, 50, clock frequency in MHz
- `STEP_MS`, 10, milliseconds per 1 % duty step
- `DEAD_MS`, 100, dwell at zero duty before a direction reversal
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command
- `cmd_dir`  in  1  target direction (0/1, same encoding as driver `dc_dir`)
- `cmd_duty`  in  8  target duty in percent
- `estop`  in  1  emergency stop, level-sensitive
- `dc_dir`  out  1  direction to PWM driver
- `dc_duty`  out  8  duty to PWM driver, 0..100
- `at_target`  out  1  high when output equals the accepted target and the block is idle

One clock, `clk`. Reset `rst` is synchronous and active-high.

## Operation
- Derived constants:
  - STEP_CYC = STEP_MS·1000·CLK_FRE.
  - DEAD_CYC = DEAD_MS·1000·CLK_FRE.
  - One shared 24-bit down-counter times both.
- Accept on `cmd_valid && cmd_ready`. `cmd_duty` > 100 is clamped to 100. The target register holds {dir, duty}. A new command overrides the previous target.
- States: IDLE, RAMP_UP, RAMP_DOWN, DWELL, STOP.
- IDLE:
  - On accept with the same dir, or with `dc_duty`==0: go to RAMP_UP if target > `dc_duty`, RAMP_DOWN if target < `dc_duty`, otherwise stay.
  - If `dc_duty`==0 and the dir differs: `dc_dir` takes the new dir on the next edge, then RAMP_UP (or IDLE if target is 0).
  - Different dir with `dc_duty`>0: set the reversal-pending flag and go to RAMP_DOWN toward 0.
- RAMP_UP / RAMP_DOWN:
  - Each expiry of STEP_CYC changes `dc_duty` by ±1.
  - On reaching the effective target (0 when reversal is pending): go to IDLE, or to DWELL if reversal is pending.
  - A command accepted mid-ramp re-evaluates direction and target without restarting the step counter. A same-dir retarget may switch RAMP_UP to RAMP_DOWN directly.
- DWELL:
  - Hold `dc_duty`=0 for DEAD_CYC.
  - Then flip `dc_dir`, clear the pending flag, and go to RAMP_UP (or IDLE if the target duty is 0).
- STOP:
  - Entered from any state when `estop`=1.
  - `dc_duty`=0, target duty cleared, pending flag cleared, `dc_dir` unchanged.
  - Leave for IDLE on the first cycle with `estop`=0.
- `cmd_ready` = 1 in IDLE, RAMP_UP and RAMP_DOWN; 0 in DWELL and STOP.
- `at_target` = 1 only in IDLE with `dc_duty`==target duty and `dc_dir`==target dir.
- Priority, highest first: `rst`, `estop`, command accept, step/dwell expiry.

## Timing
- All outputs are registered except `cmd_ready` and `at_target`, which are decoded from state/registers.
- Reset values: state IDLE, `dc_dir`=0, `dc_duty`=0, target {0,0}, `cmd_ready`=1, `at_target`=1, counter cleared.
- Commands presented while `rst`=1 are ignored.
- Step counter loads STEP_CYC−1 on ramp entry from IDLE, DWELL or STOP. `dc_duty` updates on the edge where the counter hits 0, so the first step lands STEP_CYC cycles after the accept edge. The counter then reloads.
- DWELL lasts exactly DEAD_CYC cycles. `dc_dir` flips on the edge leaving DWELL, and the first up-step comes STEP_CYC cycles later.
- `estop` rising: `dc_duty`=0 on the next edge, regardless of the counter.
- Reset mid-ramp: all registers return to reset values on that edge. No residual step is applied.

## Structure
- Package `dc_pkg`:
  - `dc_state_t` enum.
  - `DUTY_MAX`=100.
  - Function `ms_to_cyc(ms, clk_fre)` returning 24-bit cycle counts.
- Sub-module `dc_tick_gen`: loadable 24-bit down-counter with `load`, `load_val`, `en` and a one-cycle `expire` pulse. It serves both step and dwell timing.
- Top holds the FSM, the target/pending registers and the clamp.

## Test plan
Simulation parameters: `CLK_FRE`=1, `STEP_MS`=1, `DEAD_MS`=2, giving STEP_CYC=1000 and DEAD_CYC=2000.

1. Reset, then accept dir=0 duty=5 → `dc_duty` steps 1..5 at +1000, +2000 … +5000 cycles. `at_target` goes 0 at accept and 1 when `dc_duty`=5.
2. Accept duty=200 → target clamps to 100. Ramp ends at `dc_duty`=100 after 100 000 cycles.
3. At dir=0 duty=3 idle, accept dir=1 duty=2:
   - `dc_duty` falls to 0 after 3000 cycles.
   - `cmd_ready`=0 for the next 2000 cycles.
   - `dc_dir`=1 at the dwell end.
   - `dc_duty`=2 after a further 2000 cycles.
4. Ramping up to 10, at `dc_duty`=4 accept duty=2 → the next step edge (same counter phase) gives 3, then 2, then IDLE.
5. At `dc_duty`=50, assert `estop` → `dc_duty`=0 next edge, `cmd_ready`=0, a command offered is not accepted. Deassert → IDLE, `dc_duty` stays 0, `dc_dir` unchanged.
6. Assert `rst` for one cycle mid-ramp at `dc_duty`=7 → `dc_duty`=0, `dc_dir`=0, `cmd_ready`=1 on that edge. No further steps occur without a new command.
